// File: rtl/spike_psum_accum.sv
// Accumulates BATCH_NUM signed array results into a saturating partial sum and
// hands each completed group out on a valid/ready register with an 8-bit requantized value.
module spike_psum_accum #(
  parameter int BATCH_NUM = 1024,
  parameter int IN_W      = 16,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 6,
  localparam int CNT_W    = $clog2(BATCH_NUM + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        batch_cnt,
  output logic                    err_drop
);

  localparam logic signed [ACC_W:0] L_RND  = (ACC_W+1)'(1 << (SHIFT - 1));
  localparam logic signed [ACC_W:0] L_QMAX = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] L_QMIN = ~L_QMAX;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_gsat;
  logic                     r_ovalid, r_osat, r_err;
  logic signed [ACC_W-1:0]  r_oacc;
  logic signed [OUT_W-1:0]  r_oq;

  logic                     w_accept, w_last, w_load, w_ovf;
  logic signed [ACC_W-1:0]  w_base, w_acc_sat;
  logic signed [ACC_W:0]    w_sum, w_rnd, w_shr;
  logic signed [OUT_W-1:0]  w_q;

  assign w_accept = in_valid & ~clear;
  assign w_last   = w_accept & (r_cnt == CNT_W'(BATCH_NUM - 1));
  assign w_load   = w_last & (~r_ovalid | out_ready);
  assign w_base   = (r_state == S_IDLE) ? '0 : r_acc;

  // One guard bit: a sign mismatch between the top two bits means overflow.
  assign w_sum     = {w_base[ACC_W-1], w_base} + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
  assign w_ovf     = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_sat = !w_ovf        ? w_sum[ACC_W-1:0] :
                     w_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                     {1'b0, {(ACC_W-1){1'b1}}};

  assign w_rnd = {w_acc_sat[ACC_W-1], w_acc_sat} + L_RND;
  assign w_shr = w_rnd >>> SHIFT;

  always_comb begin
    w_q = w_shr[OUT_W-1:0];
    if (w_shr > L_QMAX)      w_q = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_shr < L_QMIN) w_q = {1'b1, {(OUT_W-1){1'b0}}};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !w_last) w_state_nxt = S_ACCUM;
      S_ACCUM: if (clear || w_last)     w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_gsat  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (clear || w_last) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_gsat <= 1'b0;
      end else if (w_accept) begin
        r_acc  <= w_acc_sat;
        r_cnt  <= r_cnt + CNT_W'(1);
        r_gsat <= r_gsat | w_ovf;
      end
    end
  end

  // A completed group that finds the register full and not draining is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovalid <= 1'b0;
      r_oacc   <= '0;
      r_oq     <= '0;
      r_osat   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_load) begin
        r_ovalid <= 1'b1;
        r_oacc   <= w_acc_sat;
        r_oq     <= w_q;
        r_osat   <= r_gsat | w_ovf;
      end else if (r_ovalid && out_ready) begin
        r_ovalid <= 1'b0;
      end
      if (clear)                             r_err <= 1'b0;
      else if (w_last && r_ovalid && !out_ready) r_err <= 1'b1;
    end
  end

  assign out_valid = r_ovalid;
  assign out_acc   = r_oacc;
  assign out_q     = r_oq;
  assign out_sat   = r_osat;
  assign batch_cnt = r_cnt;
  assign err_drop  = r_err;

endmodule

// File: tb/tb_spike_psum_accum.sv
// Directed bench for spike_psum_accum: three instances cover BATCH_NUM=4,
// a narrow saturating accumulator (ACC_W=20, BATCH_NUM=32) and BATCH_NUM=2.
module tb_spike_psum_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instance a: BATCH_NUM=4
  logic               a_clear = 0, a_iv = 0, a_ordy = 0;
  logic signed [15:0] a_id = 0;
  logic               a_ov, a_sat, a_err;
  logic signed [31:0] a_acc;
  logic signed [7:0]  a_q;
  logic [2:0]         a_cnt;

  // instance b: ACC_W=20, BATCH_NUM=32
  logic               b_clear = 0, b_iv = 0, b_ordy = 0;
  logic signed [15:0] b_id = 0;
  logic               b_ov, b_sat, b_err;
  logic signed [19:0] b_acc;
  logic signed [7:0]  b_q;
  logic [5:0]         b_cnt;

  // instance c: BATCH_NUM=2
  logic               c_clear = 0, c_iv = 0, c_ordy = 0;
  logic signed [15:0] c_id = 0;
  logic               c_ov, c_sat, c_err;
  logic signed [31:0] c_acc;
  logic signed [7:0]  c_q;
  logic [1:0]         c_cnt;

  spike_psum_accum #(.BATCH_NUM(4)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_iv), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_ordy), .out_acc(a_acc), .out_q(a_q),
    .out_sat(a_sat), .batch_cnt(a_cnt), .err_drop(a_err));

  spike_psum_accum #(.BATCH_NUM(32), .ACC_W(20)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_iv), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_ordy), .out_acc(b_acc), .out_q(b_q),
    .out_sat(b_sat), .batch_cnt(b_cnt), .err_drop(b_err));

  spike_psum_accum #(.BATCH_NUM(2)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clear), .in_valid(c_iv), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_ordy), .out_acc(c_acc), .out_q(c_q),
    .out_sat(c_sat), .batch_cnt(c_cnt), .err_drop(c_err));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Each push leaves in_valid high so consecutive pushes are back-to-back.
  task automatic a_push(input int v);
    a_id = 16'(v); a_iv = 1'b1; tick();
  endtask
  task automatic b_push(input int v);
    b_id = 16'(v); b_iv = 1'b1; tick();
  endtask
  task automatic c_push(input int v);
    c_id = 16'(v); c_iv = 1'b1; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (a_ov !== 1'b0)  begin n_bad++; $display("FAIL reset_ov: got %b want 0", a_ov); end
    n_cmp++; if (a_acc !== 32'sd0) begin n_bad++; $display("FAIL reset_acc: got %0d want 0", a_acc); end
    n_cmp++; if (a_q !== 8'sd0)  begin n_bad++; $display("FAIL reset_q: got %0d want 0", a_q); end
    n_cmp++; if (a_sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %b want 0", a_sat); end
    n_cmp++; if (a_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", a_err); end
    n_cmp++; if (b_ov !== 1'b0 || c_ov !== 1'b0) begin n_bad++; $display("FAIL reset_ov_bc: got %b%b want 00", b_ov, c_ov); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    a_ordy = 1'b1;
    a_push(100); a_push(-30);
    n_cmp++; if (a_cnt !== 3'd2) begin n_bad++; $display("FAIL basic_midcnt: got %0d want 2", a_cnt); end
    n_cmp++; if (a_ov !== 1'b0)  begin n_bad++; $display("FAIL basic_early_ov: got %b want 0", a_ov); end
    a_push(7); a_push(1000);
    a_iv = 1'b0;
    n_cmp++; if (a_ov !== 1'b1)      begin n_bad++; $display("FAIL basic_ov: got %b want 1", a_ov); end
    n_cmp++; if (a_acc !== 32'sd1077) begin n_bad++; $display("FAIL basic_acc: got %0d want 1077", a_acc); end
    n_cmp++; if (a_q !== 8'sd17)     begin n_bad++; $display("FAIL basic_q: got %0d want 17", a_q); end
    n_cmp++; if (a_sat !== 1'b0)     begin n_bad++; $display("FAIL basic_sat: got %b want 0", a_sat); end
    n_cmp++; if (a_cnt !== 3'd0)     begin n_bad++; $display("FAIL basic_cnt: got %0d want 0", a_cnt); end
    tick();
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL basic_consumed: got %b want 0", a_ov); end
  endtask

  task automatic test_back_to_back();
    a_ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_push(-5);
      if (i == 3 || i == 7) begin
        n_cmp++; if (a_ov !== 1'b1)       begin n_bad++; $display("FAIL b2b_ov[%0d]: got %b want 1", i, a_ov); end
        n_cmp++; if (a_acc !== -32'sd20)  begin n_bad++; $display("FAIL b2b_acc[%0d]: got %0d want -20", i, a_acc); end
        n_cmp++; if (a_q !== 8'sd0)       begin n_bad++; $display("FAIL b2b_q[%0d]: got %0d want 0", i, a_q); end
      end
      if (i == 4) begin
        n_cmp++; if (a_cnt !== 3'd1) begin n_bad++; $display("FAIL b2b_nogap_cnt: got %0d want 1", a_cnt); end
        n_cmp++; if (a_ov !== 1'b0)  begin n_bad++; $display("FAIL b2b_drain_ov: got %b want 0", a_ov); end
      end
    end
    a_iv = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    a_ordy = 1'b1;
    a_push(10); a_push(20);
    a_clear = 1'b1; a_push(99); a_clear = 1'b0;
    n_cmp++; if (a_cnt !== 3'd0) begin n_bad++; $display("FAIL clear_cnt: got %0d want 0", a_cnt); end
    a_push(1); a_push(2); a_push(3); a_push(4);
    a_iv = 1'b0;
    n_cmp++; if (a_ov !== 1'b1)      begin n_bad++; $display("FAIL clear_ov: got %b want 1", a_ov); end
    n_cmp++; if (a_acc !== 32'sd10)  begin n_bad++; $display("FAIL clear_acc: got %0d want 10", a_acc); end
    n_cmp++; if (a_err !== 1'b0)     begin n_bad++; $display("FAIL clear_err: got %b want 0", a_err); end
    tick();
    // clear coincident with what would be the completing sample
    a_push(1); a_push(1); a_push(1);
    a_clear = 1'b1; a_push(1); a_clear = 1'b0;
    a_iv = 1'b0;
    n_cmp++; if (a_ov !== 1'b0)  begin n_bad++; $display("FAIL clear_last_ov: got %b want 0", a_ov); end
    n_cmp++; if (a_cnt !== 3'd0) begin n_bad++; $display("FAIL clear_last_cnt: got %0d want 0", a_cnt); end
  endtask

  task automatic test_saturation();
    b_ordy = 1'b1;
    repeat (32) b_push(32767);
    b_iv = 1'b0;
    n_cmp++; if (b_ov !== 1'b1)         begin n_bad++; $display("FAIL sat_ov: got %b want 1", b_ov); end
    n_cmp++; if (b_acc !== 20'sd524287) begin n_bad++; $display("FAIL sat_acc: got %0d want 524287", b_acc); end
    n_cmp++; if (b_q !== 8'sd127)       begin n_bad++; $display("FAIL sat_q: got %0d want 127", b_q); end
    n_cmp++; if (b_sat !== 1'b1)        begin n_bad++; $display("FAIL sat_flag: got %b want 1", b_sat); end
    tick();
  endtask

  task automatic test_drop();
    c_ordy = 1'b0;
    c_push(1); c_push(2);
    n_cmp++; if (c_acc !== 32'sd3) begin n_bad++; $display("FAIL drop_first_acc: got %0d want 3", c_acc); end
    c_push(3); c_push(4);
    c_iv = 1'b0;
    n_cmp++; if (c_ov !== 1'b1)    begin n_bad++; $display("FAIL drop_ov: got %b want 1", c_ov); end
    n_cmp++; if (c_acc !== 32'sd3) begin n_bad++; $display("FAIL drop_held_acc: got %0d want 3", c_acc); end
    n_cmp++; if (c_err !== 1'b1)   begin n_bad++; $display("FAIL drop_err: got %b want 1", c_err); end
    c_ordy = 1'b1; tick(); c_ordy = 1'b0;
    n_cmp++; if (c_ov !== 1'b0)  begin n_bad++; $display("FAIL drop_consume_ov: got %b want 0", c_ov); end
    n_cmp++; if (c_err !== 1'b1) begin n_bad++; $display("FAIL drop_sticky: got %b want 1", c_err); end
    c_clear = 1'b1; tick(); c_clear = 1'b0;
    n_cmp++; if (c_err !== 1'b0) begin n_bad++; $display("FAIL drop_clear_err: got %b want 0", c_err); end
  endtask

  task automatic test_consume_and_load();
    c_ordy = 1'b0;
    c_push(5); c_push(6);
    n_cmp++; if (c_acc !== 32'sd11) begin n_bad++; $display("FAIL cl_first_acc: got %0d want 11", c_acc); end
    c_push(7);
    c_ordy = 1'b1; c_push(8);
    c_iv = 1'b0; c_ordy = 1'b0;
    n_cmp++; if (c_ov !== 1'b1)     begin n_bad++; $display("FAIL cl_ov: got %b want 1", c_ov); end
    n_cmp++; if (c_acc !== 32'sd15) begin n_bad++; $display("FAIL cl_acc: got %0d want 15", c_acc); end
    n_cmp++; if (c_err !== 1'b0)    begin n_bad++; $display("FAIL cl_err: got %b want 0", c_err); end
    c_ordy = 1'b1; tick();
  endtask

  task automatic test_reset_mid();
    a_ordy = 1'b0;
    a_push(1); a_push(1); a_push(1); a_push(1);
    a_iv = 1'b0;
    n_cmp++; if (a_acc !== 32'sd4) begin n_bad++; $display("FAIL rm_held_acc: got %0d want 4", a_acc); end
    a_push(10); a_push(20); a_push(30);
    a_iv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_ov !== 1'b0)    begin n_bad++; $display("FAIL rm_ov: got %b want 0", a_ov); end
    n_cmp++; if (a_acc !== 32'sd0) begin n_bad++; $display("FAIL rm_acc: got %0d want 0", a_acc); end
    n_cmp++; if (a_q !== 8'sd0)    begin n_bad++; $display("FAIL rm_q: got %0d want 0", a_q); end
    n_cmp++; if (a_cnt !== 3'd0)   begin n_bad++; $display("FAIL rm_cnt: got %0d want 0", a_cnt); end
    tick();
    rst_n = 1'b1;
    a_ordy = 1'b1;
    a_push(1); a_push(1); a_push(1); a_push(1);
    a_iv = 1'b0;
    n_cmp++; if (a_ov !== 1'b1)    begin n_bad++; $display("FAIL rm_after_ov: got %b want 1", a_ov); end
    n_cmp++; if (a_acc !== 32'sd4) begin n_bad++; $display("FAIL rm_after_acc: got %0d want 4", a_acc); end
    n_cmp++; if (a_q !== 8'sd0)    begin n_bad++; $display("FAIL rm_after_q: got %0d want 0", a_q); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clear();
    test_saturation();
    test_drop();
    test_consume_and_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
